// File: rtl/ex_alu_if.sv
// Operand/result bundle between the DEC->EX register and the execute-stage ALU.
// master drives an operation in; slave (the ALU) returns result and branch outcome.
interface ex_alu_if;
  logic        in_valid;
  logic [4:0]  in_alu_ctl;
  logic [31:0] in_op1;
  logic [31:0] in_op2;
  logic        out_valid;
  logic [31:0] out_result;
  logic        out_branch_outcome;

  modport master (
    output in_valid, in_alu_ctl, in_op1, in_op2,
    input  out_valid, out_result, out_branch_outcome
  );

  modport slave (
    input  in_valid, in_alu_ctl, in_op1, in_op2,
    output out_valid, out_result, out_branch_outcome
  );
endinterface

// File: rtl/ex_alu.sv
// MIPS32 execute-stage ALU: result/branch outcome are combinational (0 cycles), no backpressure.
// done/pass test-status flags are registered, set one edge after a valid MTC0 op.
module ex_alu (
  input  logic    clk,
  input  logic    rst_n,
  ex_alu_if.slave alu,
  output logic    done,
  output logic    pass
);

  typedef enum logic [4:0] {
    OP_NOP       = 5'd0,
    OP_ADD       = 5'd1,
    OP_ADDU      = 5'd2,
    OP_SUB       = 5'd3,
    OP_SUBU      = 5'd4,
    OP_AND       = 5'd5,
    OP_OR        = 5'd6,
    OP_XOR       = 5'd7,
    OP_NOR       = 5'd8,
    OP_SLT       = 5'd9,
    OP_SLTU      = 5'd10,
    OP_SLL       = 5'd11,
    OP_SRL       = 5'd12,
    OP_SRA       = 5'd13,
    OP_BA        = 5'd14,
    OP_BEQ       = 5'd15,
    OP_BNE       = 5'd16,
    OP_BLEZ      = 5'd17,
    OP_BGTZ      = 5'd18,
    OP_BGEZ      = 5'd19,
    OP_BLTZ      = 5'd20,
    OP_MTC0_PASS = 5'd21,
    OP_MTC0_FAIL = 5'd22,
    OP_MTC0_DONE = 5'd23
  } alu_ctl_e;

  logic [31:0] op1;
  logic [31:0] op2;
  logic [4:0]  shamt;
  logic        op1_neg;
  logic        op1_zero;
  logic [31:0] result;
  logic        taken;

  assign op1      = alu.in_op1;
  assign op2      = alu.in_op2;
  assign shamt    = op2[4:0];
  assign op1_neg  = op1[31];
  assign op1_zero = (op1 == 32'd0);

  always_comb begin
    result = 32'd0;
    taken  = 1'b0;
    case (alu_ctl_e'(alu.in_alu_ctl))
      OP_ADD, OP_ADDU: result = op1 + op2;
      OP_SUB, OP_SUBU: result = op1 - op2;
      OP_AND:          result = op1 & op2;
      OP_OR:           result = op1 | op2;
      OP_XOR:          result = op1 ^ op2;
      OP_NOR:          result = ~(op1 | op2);
      OP_SLT:          result = {31'd0, $signed(op1) < $signed(op2)};
      OP_SLTU:         result = {31'd0, op1 < op2};
      OP_SLL:          result = op1 << shamt;
      OP_SRL:          result = op1 >> shamt;
      OP_SRA:          result = $unsigned($signed(op1) >>> shamt);
      OP_BA:           taken  = 1'b1;
      OP_BEQ:          taken  = (op1 == op2);
      OP_BNE:          taken  = (op1 != op2);
      OP_BLEZ:         taken  = op1_neg | op1_zero;
      OP_BGTZ:         taken  = ~op1_neg & ~op1_zero;
      OP_BGEZ:         taken  = ~op1_neg;
      OP_BLTZ:         taken  = op1_neg;
      default:         ;
    endcase
    if (!alu.in_valid) begin
      result = 32'd0;
      taken  = 1'b0;
    end
  end

  assign alu.out_valid          = alu.in_valid;
  assign alu.out_result         = result;
  assign alu.out_branch_outcome = taken;

  // done is sticky so a stalled, repeated MTC0 cannot rewrite pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      pass <= 1'b0;
    end else if (alu.in_valid && !done) begin
      case (alu_ctl_e'(alu.in_alu_ctl))
        OP_MTC0_PASS: begin
          done <= 1'b1;
          pass <= 1'b1;
        end
        OP_MTC0_FAIL: begin
          done <= 1'b1;
          pass <= 1'b0;
        end
        OP_MTC0_DONE: done <= 1'b1;
        default:      ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_alu.sv
// Directed-vector bench for ex_alu: combinational ops, branches, and sticky test flags.
module tb_ex_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic done;
  logic pass;
  int   checks = 0;
  int   errors = 0;

  ex_alu_if alu_if ();

  ex_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .alu   (alu_if.slave),
    .done  (done),
    .pass  (pass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic v, input logic [4:0] ctl, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    alu_if.in_valid   = v;
    alu_if.in_alu_ctl = ctl;
    alu_if.in_op1     = a;
    alu_if.in_op2     = b;
    #1;
  endtask

  task automatic chk_op(input string tag, input logic [31:0] exp_res, input logic exp_br);
    chk({tag, "_res"}, alu_if.out_result, exp_res);
    chk({tag, "_br"}, {31'd0, alu_if.out_branch_outcome}, {31'd0, exp_br});
  endtask

  task automatic chk_flags(input string tag, input logic exp_done, input logic exp_pass);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
    chk({tag, "_pass"}, {31'd0, pass}, {31'd0, exp_pass});
  endtask

  initial begin
    alu_if.in_valid   = 1'b0;
    alu_if.in_alu_ctl = 5'd0;
    alu_if.in_op1     = 32'd0;
    alu_if.in_op2     = 32'd0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk_flags("reset", 1'b0, 1'b0);
    rst_n = 1'b1;

    drive(1'b1, 5'd1, 32'h7FFF_FFFF, 32'h0000_0001);
    chk_op("add_ovf", 32'h8000_0000, 1'b0);
    chk("valid", {31'd0, alu_if.out_valid}, 32'd1);
    drive(1'b1, 5'd4, 32'h0000_0000, 32'h0000_0001);
    chk_op("subu", 32'hFFFF_FFFF, 1'b0);
    drive(1'b1, 5'd3, 32'h0000_0010, 32'h0000_0003);
    chk_op("sub", 32'h0000_000D, 1'b0);
    drive(1'b1, 5'd8, 32'h0F0F_0000, 32'h0000_00FF);
    chk_op("nor", 32'hF0F0_FF00, 1'b0);
    drive(1'b1, 5'd5, 32'hFF00_FF00, 32'h0FF0_0FF0);
    chk_op("and", 32'h0F00_0F00, 1'b0);
    drive(1'b1, 5'd6, 32'hFF00_FF00, 32'h0FF0_0FF0);
    chk_op("or", 32'hFFF0_FFF0, 1'b0);
    drive(1'b1, 5'd7, 32'hFF00_FF00, 32'h0FF0_0FF0);
    chk_op("xor", 32'hF0F0_F0F0, 1'b0);
    drive(1'b1, 5'd9, 32'hFFFF_FFFF, 32'h0000_0001);
    chk_op("slt", 32'h0000_0001, 1'b0);
    drive(1'b1, 5'd10, 32'hFFFF_FFFF, 32'h0000_0001);
    chk_op("sltu", 32'h0000_0000, 1'b0);
    drive(1'b1, 5'd13, 32'h8000_0010, 32'h0000_0004);
    chk_op("sra", 32'hF800_0001, 1'b0);
    drive(1'b1, 5'd12, 32'h8000_0010, 32'h0000_0004);
    chk_op("srl", 32'h0800_0001, 1'b0);
    drive(1'b1, 5'd11, 32'h8000_0010, 32'h0000_0021);
    chk_op("sll", 32'h0000_0020, 1'b0);

    drive(1'b1, 5'd15, 32'd5, 32'd5);
    chk_op("beq_eq", 32'd0, 1'b1);
    drive(1'b1, 5'd16, 32'd5, 32'd5);
    chk_op("bne_eq", 32'd0, 1'b0);
    drive(1'b1, 5'd17, 32'd0, 32'hFFFF_FFFF);
    chk_op("blez_0", 32'd0, 1'b1);
    drive(1'b1, 5'd18, 32'd0, 32'd0);
    chk_op("bgtz_0", 32'd0, 1'b0);
    drive(1'b1, 5'd19, 32'h8000_0000, 32'd0);
    chk_op("bgez_neg", 32'd0, 1'b0);
    drive(1'b1, 5'd20, 32'h8000_0000, 32'd0);
    chk_op("bltz_min", 32'd0, 1'b1);
    drive(1'b1, 5'd14, 32'd0, 32'd0);
    chk_op("ba", 32'd0, 1'b1);
    drive(1'b1, 5'd1, 32'd5, 32'd5);
    chk_op("add55", 32'd10, 1'b0);
    drive(1'b1, 5'd27, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_op("code27", 32'd0, 1'b0);
    chk_flags("nonmtc0", 1'b0, 1'b0);

    drive(1'b1, 5'd22, 32'd0, 32'd0);
    chk_op("mtc0_fail", 32'd0, 1'b0);
    @(posedge clk);
    #1;
    chk_flags("after_fail", 1'b1, 1'b0);
    drive(1'b1, 5'd21, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    chk_flags("pass_ignored", 1'b1, 1'b0);

    // Reset lands mid-cycle with a valid MTC0_PASS still presented.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_flags("async_rst", 1'b0, 1'b0);
    drive(1'b0, 5'd21, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rst_n = 1'b1;
    chk("inv_valid", {31'd0, alu_if.out_valid}, 32'd0);
    chk_op("inv", 32'd0, 1'b0);
    @(posedge clk);
    #1;
    chk_flags("inv_noupd", 1'b0, 1'b0);

    drive(1'b1, 5'd21, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    chk_flags("after_pass", 1'b1, 1'b1);
    drive(1'b1, 5'd22, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    chk_flags("fail_ignored", 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
